// File: rtl/atom_wb_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// atom_wb_arbiter_pkg
// Shared definitions for the Atom IBUS/DBUS Wishbone arbiter:
//   - arbiter FSM state encoding
//   - port-index constants (IBUS = 0, DBUS = 1)
//   - default timeout parameters
//   - round-robin winner selection helper
// ----------------------------------------------------------------------------
package atom_wb_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GNT_I = 2'd1,
        ST_GNT_D = 2'd2
    } arb_state_e;

    localparam logic        PORT_IBUS              = 1'b0;
    localparam logic        PORT_DBUS              = 1'b1;
    localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 32'd255;
    localparam logic [31:0] DEFAULT_TIMEOUT_DATA   = 32'hDEAD_BEEF;

    // Winner among the pending requesters; on a conflict the port that was
    // not granted last wins. Only meaningful when at least one port requests.
    function automatic logic rr_pick(input logic ib_req,
                                     input logic db_req,
                                     input logic last_gnt);
        logic pick;
        if (ib_req && db_req) begin
            pick = ~last_gnt;
        end else if (db_req) begin
            pick = PORT_DBUS;
        end else begin
            pick = PORT_IBUS;
        end
        return pick;
    endfunction

endpackage

// File: rtl/atom_wb_timeout_cnt.sv
// ----------------------------------------------------------------------------
// atom_wb_timeout_cnt
// Wait-cycle counter for a granted transaction. Only instantiated when
// ATOM_WB_ARB_TIMEOUT_EN is defined.
//   clk    : clock
//   rst_n  : asynchronous active-low reset
//   clr    : hold the count at zero (arbiter idle, so a new grant starts at 0)
//   en     : one more cycle waited without an acknowledge
//   expire : the current cycle is wait cycle number LIMIT
// ----------------------------------------------------------------------------
module atom_wb_timeout_cnt #(
    parameter int unsigned LIMIT = 32'd255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam int unsigned     CNT_W     = $clog2(LIMIT + 32'd1);
    // count_r holds the number of wait cycles already completed, so the
    // LIMIT-th wait cycle is the one that sees LIMIT-1.
    localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(LIMIT - 32'd1);

    logic [CNT_W-1:0] count_r;

    // Wait-cycle count: cleared while idle, saturates at the expiry value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r <= {CNT_W{1'b0}};
        end else if (clr) begin
            count_r <= {CNT_W{1'b0}};
        end else if (en && (count_r != LAST_WAIT)) begin
            count_r <= count_r + CNT_W'(1);
        end else begin
            count_r <= count_r;
        end
    end

    assign expire = ~clr & (count_r == LAST_WAIT);

endmodule

// File: rtl/atom_wb_arbiter.sv
// ----------------------------------------------------------------------------
// atom_wb_arbiter
// Two-to-one Wishbone arbiter merging the Atom core IBUS (read-only) and DBUS
// masters onto one shared Wishbone master. One grant at a time, round-robin
// on conflicts, ack routed only to the granted port.
//
// Optional feature macro: ATOM_WB_ARB_TIMEOUT_EN
//   defined   : a grant waiting TIMEOUT_CYCLES cycles without m_ack_i is
//               terminated with a one-cycle ack carrying TIMEOUT_DATA, and
//               the sticky timeout_o flag is set.
//   undefined : a grant waits indefinitely; timeout_o is tied 0.
//
// Ports
//   wb_clk_i, wb_rst_i           : clock, asynchronous active-low reset
//   ib_adr_i, ib_stb_i           : IBUS request (read, all bytes)
//   ib_dat_o, ib_ack_o           : IBUS response
//   db_adr_i, db_dat_i, db_we_i,
//   db_sel_i, db_stb_i, db_cyc_i : DBUS request
//   db_dat_o, db_ack_o           : DBUS response
//   m_adr_o .. m_cyc_o           : shared master request
//   m_dat_i, m_ack_i             : shared master response
//   timeout_o                    : sticky timeout flag
// ----------------------------------------------------------------------------
module atom_wb_arbiter
    import atom_wb_arbiter_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
    parameter logic [31:0] TIMEOUT_DATA   = DEFAULT_TIMEOUT_DATA
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic [31:0] ib_adr_i,
    input  logic        ib_stb_i,
    output logic [31:0] ib_dat_o,
    output logic        ib_ack_o,
    input  logic [31:0] db_adr_i,
    input  logic [31:0] db_dat_i,
    input  logic        db_we_i,
    input  logic [3:0]  db_sel_i,
    input  logic        db_stb_i,
    input  logic        db_cyc_i,
    output logic [31:0] db_dat_o,
    output logic        db_ack_o,
    output logic [31:0] m_adr_o,
    output logic [31:0] m_dat_o,
    output logic        m_we_o,
    output logic [3:0]  m_sel_o,
    output logic        m_stb_o,
    output logic        m_cyc_o,
    input  logic [31:0] m_dat_i,
    input  logic        m_ack_i,
    output logic        timeout_o
);

    arb_state_e state_r;
    logic       last_gnt_r;

    logic ib_req_s;
    logic db_req_s;
    logic gnt_i_s;
    logic gnt_d_s;
    logic idle_s;
    logic gnt_req_s;
    logic expire_s;
    logic timeout_hit_s;
    logic done_s;

    assign ib_req_s  = ib_stb_i;
    assign db_req_s  = db_stb_i & db_cyc_i;
    assign gnt_i_s   = (state_r == ST_GNT_I);
    assign gnt_d_s   = (state_r == ST_GNT_D);
    assign idle_s    = (state_r == ST_IDLE);
    // Granted port is still asking; dropping it aborts the transaction.
    assign gnt_req_s = (gnt_i_s & ib_req_s) | (gnt_d_s & db_req_s);

`ifdef ATOM_WB_ARB_TIMEOUT_EN
    logic cnt_expire_s;
    logic timeout_r;

    atom_wb_timeout_cnt #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_timeout_cnt (
        .clk    (wb_clk_i),
        .rst_n  (wb_rst_i),
        .clr    (idle_s),
        .en     (gnt_req_s & ~m_ack_i),
        .expire (cnt_expire_s)
    );

    assign expire_s = cnt_expire_s & gnt_req_s;

    // Sticky timeout flag; a real slave ack on the expiry cycle does not set it.
    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            timeout_r <= 1'b0;
        end else if (expire_s && !m_ack_i) begin
            timeout_r <= 1'b1;
        end else begin
            timeout_r <= timeout_r;
        end
    end

    assign timeout_o = timeout_r;
`else
    logic [31:0] cfg_unused_s;

    assign expire_s     = 1'b0;
    assign timeout_o    = 1'b0;
    assign cfg_unused_s = 32'(TIMEOUT_CYCLES);
`endif

    // Forced termination only when the slave did not answer on that cycle.
    assign timeout_hit_s = expire_s & ~m_ack_i;
    assign done_s        = ~gnt_req_s | m_ack_i | expire_s;

    // Grant FSM: one idle cycle between transactions, round-robin on conflicts.
    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            state_r    <= ST_IDLE;
            last_gnt_r <= PORT_IBUS;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (ib_req_s || db_req_s) begin
                        if (rr_pick(ib_req_s, db_req_s, last_gnt_r) == PORT_DBUS) begin
                            state_r    <= ST_GNT_D;
                            last_gnt_r <= PORT_DBUS;
                        end else begin
                            state_r    <= ST_GNT_I;
                            last_gnt_r <= PORT_IBUS;
                        end
                    end else begin
                        state_r    <= ST_IDLE;
                        last_gnt_r <= last_gnt_r;
                    end
                end
                ST_GNT_I, ST_GNT_D: begin
                    if (done_s) begin
                        state_r <= ST_IDLE;
                    end else begin
                        state_r <= state_r;
                    end
                    last_gnt_r <= last_gnt_r;
                end
                default: begin
                    state_r    <= ST_IDLE;
                    last_gnt_r <= last_gnt_r;
                end
            endcase
        end
    end

    // Master request mux; follows the state so reset drops stb/cyc immediately.
    always_comb begin
        m_adr_o = 32'h0000_0000;
        m_dat_o = 32'h0000_0000;
        m_we_o  = 1'b0;
        m_sel_o = 4'h0;
        m_stb_o = 1'b0;
        case (state_r)
            ST_GNT_I: begin
                m_adr_o = ib_adr_i;
                m_sel_o = 4'hF;
                m_stb_o = ib_req_s & ~expire_s;
            end
            ST_GNT_D: begin
                m_adr_o = db_adr_i;
                m_dat_o = db_dat_i;
                m_we_o  = db_we_i;
                m_sel_o = db_sel_i;
                m_stb_o = db_req_s & ~expire_s;
            end
            default: begin
                m_stb_o = 1'b0;
            end
        endcase
        m_cyc_o = m_stb_o;
    end

    assign ib_ack_o = gnt_i_s & ib_req_s & (m_ack_i | expire_s);
    assign db_ack_o = gnt_d_s & db_req_s & (m_ack_i | expire_s);

    // Read data is broadcast; only a forced termination substitutes the
    // timeout pattern on the granted port. Held at zero during reset.
    assign ib_dat_o = !wb_rst_i ? 32'h0000_0000 :
                      ((gnt_i_s & timeout_hit_s) ? TIMEOUT_DATA : m_dat_i);
    assign db_dat_o = !wb_rst_i ? 32'h0000_0000 :
                      ((gnt_d_s & timeout_hit_s) ? TIMEOUT_DATA : m_dat_i);

endmodule

// File: tb/tb_atom_wb_arbiter.sv
// ----------------------------------------------------------------------------
// tb_atom_wb_arbiter
// Self-checking bench for atom_wb_arbiter. Inputs change 1 time unit after a
// rising edge; outputs are sampled on the falling edge. The expected grant
// order comes from a round-robin model (model_last = last port served).
// The timeout scenario follows ATOM_WB_ARB_TIMEOUT_EN.
// ----------------------------------------------------------------------------
module tb_atom_wb_arbiter;

    localparam int unsigned TB_TIMEOUT = 8;

    logic        wb_clk_i;
    logic        wb_rst_i;
    logic [31:0] ib_adr_i;
    logic        ib_stb_i;
    logic [31:0] ib_dat_o;
    logic        ib_ack_o;
    logic [31:0] db_adr_i;
    logic [31:0] db_dat_i;
    logic        db_we_i;
    logic [3:0]  db_sel_i;
    logic        db_stb_i;
    logic        db_cyc_i;
    logic [31:0] db_dat_o;
    logic        db_ack_o;
    logic [31:0] m_adr_o;
    logic [31:0] m_dat_o;
    logic        m_we_o;
    logic [3:0]  m_sel_o;
    logic        m_stb_o;
    logic        m_cyc_o;
    logic [31:0] m_dat_i;
    logic        m_ack_i;
    logic        timeout_o;

    int   checks = 0;
    int   errors = 0;
    logic model_last;   // 0 = IBUS served last, 1 = DBUS served last

    atom_wb_arbiter #(
        .TIMEOUT_CYCLES (TB_TIMEOUT),
        .TIMEOUT_DATA   (32'hDEAD_BEEF)
    ) dut (
        .wb_clk_i  (wb_clk_i),
        .wb_rst_i  (wb_rst_i),
        .ib_adr_i  (ib_adr_i),
        .ib_stb_i  (ib_stb_i),
        .ib_dat_o  (ib_dat_o),
        .ib_ack_o  (ib_ack_o),
        .db_adr_i  (db_adr_i),
        .db_dat_i  (db_dat_i),
        .db_we_i   (db_we_i),
        .db_sel_i  (db_sel_i),
        .db_stb_i  (db_stb_i),
        .db_cyc_i  (db_cyc_i),
        .db_dat_o  (db_dat_o),
        .db_ack_o  (db_ack_o),
        .m_adr_o   (m_adr_o),
        .m_dat_o   (m_dat_o),
        .m_we_o    (m_we_o),
        .m_sel_o   (m_sel_o),
        .m_stb_o   (m_stb_o),
        .m_cyc_o   (m_cyc_o),
        .m_dat_i   (m_dat_i),
        .m_ack_i   (m_ack_i),
        .timeout_o (timeout_o)
    );

    initial begin
        wb_clk_i = 1'b0;
        forever #5 wb_clk_i = ~wb_clk_i;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic step();
        @(posedge wb_clk_i);
        #1;
    endtask

    task automatic drive_idle();
        ib_adr_i = 32'h0; ib_stb_i = 1'b0;
        db_adr_i = 32'h0; db_dat_i = 32'h0; db_we_i = 1'b0; db_sel_i = 4'h0;
        db_stb_i = 1'b0;  db_cyc_i = 1'b0;
        m_dat_i  = 32'h0; m_ack_i  = 1'b0;
    endtask

    task automatic test_reset();
        wb_rst_i = 1'b0;
        ib_adr_i = $urandom; ib_stb_i = 1'b1;
        db_adr_i = $urandom; db_dat_i = $urandom; db_we_i = 1'b1; db_sel_i = 4'hF;
        db_stb_i = 1'b1; db_cyc_i = 1'b1;
        m_dat_i = 32'hCAFE_F00D; m_ack_i = 1'b1;
        repeat (2) @(posedge wb_clk_i);
        @(negedge wb_clk_i);
        checks++;
        if ({m_stb_o, m_cyc_o, m_we_o, m_sel_o} !== 7'h00) begin
            errors++; $display("FAIL reset_ctrl: stb/cyc/we/sel=%h expected 00", {m_stb_o, m_cyc_o, m_we_o, m_sel_o});
        end
        checks++;
        if ({m_adr_o, m_dat_o} !== 64'h0) begin
            errors++; $display("FAIL reset_mbus: adr=%h dat=%h expected 0", m_adr_o, m_dat_o);
        end
        checks++;
        if ({ib_ack_o, db_ack_o, timeout_o} !== 3'b000) begin
            errors++; $display("FAIL reset_ack: ib/db/timeout=%b expected 000", {ib_ack_o, db_ack_o, timeout_o});
        end
        checks++;
        if ({ib_dat_o, db_dat_o} !== 64'h0) begin
            errors++; $display("FAIL reset_rdata: ib=%h db=%h expected 0", ib_dat_o, db_dat_o);
        end
        drive_idle();
        wb_rst_i = 1'b1;
        model_last = 1'b0;
        step();
    endtask

    task automatic test_conflict();
        ib_adr_i = 32'h0000_0300; ib_stb_i = 1'b1;
        db_adr_i = 32'h0000_0200; db_dat_i = 32'hA5A5_A5A5; db_we_i = 1'b1; db_sel_i = 4'b0011;
        db_stb_i = 1'b1; db_cyc_i = 1'b1;
        @(negedge wb_clk_i);
        checks++;
        if (m_stb_o !== 1'b0) begin
            errors++; $display("FAIL conflict_latency: m_stb_o=%b expected 0", m_stb_o);
        end
        step();
        m_ack_i = 1'b1; m_dat_i = 32'h0BAD_F00D;
        @(negedge wb_clk_i);
        checks++;
        if ({m_adr_o, m_dat_o, m_we_o, m_sel_o, m_stb_o, m_cyc_o} !==
            {32'h0000_0200, 32'hA5A5_A5A5, 1'b1, 4'b0011, 1'b1, 1'b1}) begin
            errors++; $display("FAIL conflict_dbus_first: adr=%h dat=%h we=%b sel=%b stb=%b expected 200 a5a5a5a5 1 0011 1",
                               m_adr_o, m_dat_o, m_we_o, m_sel_o, m_stb_o);
        end
        checks++;
        if ({ib_ack_o, db_ack_o} !== 2'b01) begin
            errors++; $display("FAIL conflict_dbus_ack: ib/db ack=%b expected 01", {ib_ack_o, db_ack_o});
        end
        step();
        m_ack_i = 1'b0; db_stb_i = 1'b0; db_cyc_i = 1'b0; db_we_i = 1'b0;
        @(negedge wb_clk_i);
        checks++;
        if ({m_stb_o, ib_ack_o} !== 2'b00) begin
            errors++; $display("FAIL conflict_idle_gap: stb/ib_ack=%b expected 00", {m_stb_o, ib_ack_o});
        end
        step();
        m_ack_i = 1'b1; m_dat_i = 32'h1357_9BDF;
        @(negedge wb_clk_i);
        checks++;
        if ({m_adr_o, m_dat_o, m_we_o, m_sel_o, m_stb_o} !== {32'h0000_0300, 32'h0, 1'b0, 4'hF, 1'b1}) begin
            errors++; $display("FAIL conflict_ibus_next: adr=%h dat=%h we=%b sel=%h stb=%b expected 300 0 0 f 1",
                               m_adr_o, m_dat_o, m_we_o, m_sel_o, m_stb_o);
        end
        checks++;
        if ({ib_ack_o, db_ack_o, ib_dat_o} !== {2'b10, 32'h1357_9BDF}) begin
            errors++; $display("FAIL conflict_ibus_ack: acks=%b data=%h expected 10 13579bdf", {ib_ack_o, db_ack_o}, ib_dat_o);
        end
        step();
        drive_idle();
        model_last = 1'b0;
    endtask

    task automatic test_ibus_read();
        ib_adr_i = 32'h0000_0100; ib_stb_i = 1'b1;
        @(negedge wb_clk_i);
        checks++;
        if (m_stb_o !== 1'b0) begin
            errors++; $display("FAIL ibus_latency: m_stb_o=%b expected 0 in request cycle", m_stb_o);
        end
        step();
        for (int w = 0; w < 2; w++) begin
            @(negedge wb_clk_i);
            checks++;
            if ({m_stb_o, m_cyc_o, m_adr_o, m_we_o, m_sel_o, ib_ack_o, db_ack_o} !==
                {1'b1, 1'b1, 32'h0000_0100, 1'b0, 4'hF, 2'b00}) begin
                errors++; $display("FAIL ibus_wait%0d: stb=%b adr=%h sel=%h acks=%b expected 1 100 f 00",
                                   w, m_stb_o, m_adr_o, m_sel_o, {ib_ack_o, db_ack_o});
            end
            step();
        end
        m_ack_i = 1'b1; m_dat_i = 32'h1234_5678;
        @(negedge wb_clk_i);
        checks++;
        if ({ib_ack_o, db_ack_o, ib_dat_o} !== {2'b10, 32'h1234_5678}) begin
            errors++; $display("FAIL ibus_ack: acks=%b data=%h expected 10 12345678", {ib_ack_o, db_ack_o}, ib_dat_o);
        end
        step();
        m_ack_i = 1'b0; ib_stb_i = 1'b0;
        @(negedge wb_clk_i);
        checks++;
        if (m_stb_o !== 1'b0) begin
            errors++; $display("FAIL ibus_done: m_stb_o=%b expected 0", m_stb_o);
        end
        step();
        drive_idle();
        model_last = 1'b0;
    endtask

    task automatic test_alternate();
        logic        exp_d, we, exp_we;
        logic [31:0] ia, da, dd, rd, exp_adr, exp_mdat;
        logic [3:0]  sel, exp_sel;
        int          waits;
        exp_d = ~model_last;
        for (int t = 0; t < 10; t++) begin
            ia = $urandom; da = $urandom; dd = $urandom; rd = $urandom;
            we = 1'($urandom_range(0, 1)); sel = 4'($urandom_range(0, 15));
            waits = int'($urandom_range(0, 2));
            ib_adr_i = ia; ib_stb_i = 1'b1;
            db_adr_i = da; db_dat_i = dd; db_we_i = we; db_sel_i = sel; db_stb_i = 1'b1; db_cyc_i = 1'b1;
            exp_adr  = exp_d ? da : ia;
            exp_mdat = exp_d ? dd : 32'h0;
            exp_we   = exp_d ? we : 1'b0;
            exp_sel  = exp_d ? sel : 4'hF;
            @(negedge wb_clk_i);
            checks++;
            if (m_stb_o !== 1'b0) begin
                errors++; $display("FAIL alt_idle_gap t=%0d: m_stb_o=%b expected 0", t, m_stb_o);
            end
            step();
            for (int w = 0; w < waits; w++) begin
                @(negedge wb_clk_i);
                checks++;
                if ({m_stb_o, m_adr_o, ib_ack_o, db_ack_o} !== {1'b1, exp_adr, 2'b00}) begin
                    errors++; $display("FAIL alt_wait t=%0d: stb=%b adr=%h acks=%b expected 1 %h 00",
                                       t, m_stb_o, m_adr_o, {ib_ack_o, db_ack_o}, exp_adr);
                end
                step();
            end
            m_ack_i = 1'b1; m_dat_i = rd;
            @(negedge wb_clk_i);
            checks++;
            if ({m_adr_o, m_dat_o, m_we_o, m_sel_o, m_stb_o, m_cyc_o} !== {exp_adr, exp_mdat, exp_we, exp_sel, 2'b11}) begin
                errors++; $display("FAIL alt_fields t=%0d: adr=%h dat=%h we=%b sel=%h expected %h %h %b %h (dbus=%b)",
                                   t, m_adr_o, m_dat_o, m_we_o, m_sel_o, exp_adr, exp_mdat, exp_we, exp_sel, exp_d);
            end
            checks++;
            if ({ib_ack_o, db_ack_o} !== {~exp_d, exp_d}) begin
                errors++; $display("FAIL alt_ack t=%0d: ib/db ack=%b expected %b", t, {ib_ack_o, db_ack_o}, {~exp_d, exp_d});
            end
            checks++;
            if ((exp_d ? db_dat_o : ib_dat_o) !== rd) begin
                errors++; $display("FAIL alt_rdata t=%0d: ib=%h db=%h expected %h", t, ib_dat_o, db_dat_o, rd);
            end
            step();
            m_ack_i = 1'b0;
            model_last = exp_d;
            exp_d = ~exp_d;
        end
        drive_idle();
    endtask

    task automatic test_reset_mid();
        db_adr_i = 32'h0000_0400; db_sel_i = 4'hF; db_stb_i = 1'b1; db_cyc_i = 1'b1;
        step();
        @(negedge wb_clk_i);
        checks++;
        if ({m_stb_o, m_adr_o} !== {1'b1, 32'h0000_0400}) begin
            errors++; $display("FAIL rstmid_grant: stb=%b adr=%h expected 1 400", m_stb_o, m_adr_o);
        end
        #2;
        wb_rst_i = 1'b0;
        #1;
        checks++;
        if ({m_stb_o, m_cyc_o} !== 2'b00) begin
            errors++; $display("FAIL rstmid_async_drop: stb/cyc=%b expected 00", {m_stb_o, m_cyc_o});
        end
        m_ack_i = 1'b1; m_dat_i = $urandom;
        step();
        wb_rst_i = 1'b1; db_stb_i = 1'b0; db_cyc_i = 1'b0;
        @(negedge wb_clk_i);
        checks++;
        if ({m_stb_o, ib_ack_o, db_ack_o} !== 3'b000) begin
            errors++; $display("FAIL rstmid_stale_ack: stb/ib_ack/db_ack=%b expected 000", {m_stb_o, ib_ack_o, db_ack_o});
        end
        step();
        model_last = 1'b0;
        // Conflict after reset must favour DBUS again.
        m_ack_i = 1'b0;
        ib_adr_i = 32'h0000_0A00; ib_stb_i = 1'b1;
        db_adr_i = 32'h0000_0B00; db_stb_i = 1'b1; db_cyc_i = 1'b1;
        step();
        m_ack_i = 1'b1; m_dat_i = 32'h7777_0000;
        @(negedge wb_clk_i);
        checks++;
        if ({m_adr_o, db_ack_o, ib_ack_o} !== {32'h0000_0B00, 2'b10}) begin
            errors++; $display("FAIL rstmid_lastgnt: adr=%h db/ib ack=%b expected b00 10", m_adr_o, {db_ack_o, ib_ack_o});
        end
        step();
        drive_idle();
        model_last = 1'b1;
    endtask

    task automatic test_abort();
        db_adr_i = 32'h0000_0500; db_sel_i = 4'h3; db_stb_i = 1'b1; db_cyc_i = 1'b1;
        step();
        @(negedge wb_clk_i);
        checks++;
        if (m_stb_o !== 1'b1) begin
            errors++; $display("FAIL abort_grant: m_stb_o=%b expected 1", m_stb_o);
        end
        step();
        db_stb_i = 1'b0;
        @(negedge wb_clk_i);
        checks++;
        if ({m_stb_o, db_ack_o} !== 2'b00) begin
            errors++; $display("FAIL abort_drop: stb/db_ack=%b expected 00", {m_stb_o, db_ack_o});
        end
        step();
        db_cyc_i = 1'b0; ib_adr_i = 32'h0000_0600; ib_stb_i = 1'b1;
        @(negedge wb_clk_i);
        checks++;
        if ({m_stb_o, db_ack_o} !== 2'b00) begin
            errors++; $display("FAIL abort_idle: stb/db_ack=%b expected 00", {m_stb_o, db_ack_o});
        end
        step();
        m_ack_i = 1'b1; m_dat_i = 32'h600D_CAFE;
        @(negedge wb_clk_i);
        checks++;
        if ({m_adr_o, ib_ack_o, db_ack_o, ib_dat_o} !== {32'h0000_0600, 2'b10, 32'h600D_CAFE}) begin
            errors++; $display("FAIL abort_next_ibus: adr=%h acks=%b data=%h expected 600 10 600dcafe",
                               m_adr_o, {ib_ack_o, db_ack_o}, ib_dat_o);
        end
        step();
        drive_idle();
        model_last = 1'b0;
    endtask

    task automatic test_random_mix();
        logic [1:0]  pat;
        logic        win_d;
        logic [31:0] ia, da, rd;
        int          waits;
        for (int t = 0; t < 12; t++) begin
            pat   = 2'($urandom_range(1, 3));
            win_d = (pat == 2'b11) ? ~model_last : pat[1];
            ia = $urandom; da = $urandom; rd = $urandom;
            waits = int'($urandom_range(0, 2));
            ib_adr_i = ia; ib_stb_i = pat[0];
            db_adr_i = da; db_dat_i = $urandom; db_we_i = 1'($urandom_range(0, 1));
            db_sel_i = 4'($urandom_range(0, 15));
            db_cyc_i = pat[1];
            db_stb_i = pat[1] ? 1'b1 : 1'($urandom_range(0, 1));
            @(negedge wb_clk_i);
            checks++;
            if (m_stb_o !== 1'b0) begin
                errors++; $display("FAIL mix_idle t=%0d: m_stb_o=%b expected 0", t, m_stb_o);
            end
            step();
            for (int w = 0; w < waits; w++) begin
                @(negedge wb_clk_i);
                checks++;
                if ({m_stb_o, m_adr_o, ib_ack_o, db_ack_o} !== {1'b1, (win_d ? da : ia), 2'b00}) begin
                    errors++; $display("FAIL mix_wait t=%0d: stb=%b adr=%h acks=%b expected 1 %h 00",
                                       t, m_stb_o, m_adr_o, {ib_ack_o, db_ack_o}, (win_d ? da : ia));
                end
                step();
            end
            m_ack_i = 1'b1; m_dat_i = rd;
            @(negedge wb_clk_i);
            checks++;
            if ({m_adr_o, ib_ack_o, db_ack_o} !== {(win_d ? da : ia), ~win_d, win_d}) begin
                errors++; $display("FAIL mix_grant t=%0d pat=%b: adr=%h acks=%b expected %h %b",
                                   t, pat, m_adr_o, {ib_ack_o, db_ack_o}, (win_d ? da : ia), {~win_d, win_d});
            end
            checks++;
            if ((win_d ? db_dat_o : ib_dat_o) !== rd) begin
                errors++; $display("FAIL mix_rdata t=%0d: ib=%h db=%h expected %h", t, ib_dat_o, db_dat_o, rd);
            end
            step();
            m_ack_i = 1'b0;
            model_last = win_d;
        end
        drive_idle();
    endtask

    task automatic test_timeout();
`ifdef ATOM_WB_ARB_TIMEOUT_EN
        // Real ack on the expiry cycle wins.
        db_adr_i = 32'h0000_0700; db_sel_i = 4'hF; db_stb_i = 1'b1; db_cyc_i = 1'b1;
        step();
        for (int k = 1; k < int'(TB_TIMEOUT); k++) begin
            @(negedge wb_clk_i);
            checks++;
            if ({m_stb_o, db_ack_o} !== 2'b10) begin
                errors++; $display("FAIL to_win_wait%0d: stb/db_ack=%b expected 10", k, {m_stb_o, db_ack_o});
            end
            step();
        end
        m_ack_i = 1'b1; m_dat_i = 32'h1111_2222;
        @(negedge wb_clk_i);
        checks++;
        if ({db_ack_o, db_dat_o} !== {1'b1, 32'h1111_2222}) begin
            errors++; $display("FAIL to_win_data: ack=%b data=%h expected 1 11112222", db_ack_o, db_dat_o);
        end
        step();
        drive_idle();
        @(negedge wb_clk_i);
        checks++;
        if (timeout_o !== 1'b0) begin
            errors++; $display("FAIL to_win_flag: timeout_o=%b expected 0", timeout_o);
        end
        // Slave never answers.
        ib_adr_i = 32'h0000_0800; ib_stb_i = 1'b1;
        step();
        for (int k = 1; k < int'(TB_TIMEOUT); k++) begin
            @(negedge wb_clk_i);
            checks++;
            if ({m_stb_o, ib_ack_o, timeout_o} !== 3'b100) begin
                errors++; $display("FAIL to_wait%0d: stb/ib_ack/timeout=%b expected 100", k, {m_stb_o, ib_ack_o, timeout_o});
            end
            step();
        end
        m_dat_i = 32'h5555_5555;
        @(negedge wb_clk_i);
        checks++;
        if ({ib_ack_o, ib_dat_o, m_stb_o, m_cyc_o} !== {1'b1, 32'hDEAD_BEEF, 2'b00}) begin
            errors++; $display("FAIL to_expire: ack=%b data=%h stb/cyc=%b expected 1 deadbeef 00",
                               ib_ack_o, ib_dat_o, {m_stb_o, m_cyc_o});
        end
        step();
        ib_stb_i = 1'b0;
        @(negedge wb_clk_i);
        checks++;
        if ({timeout_o, m_stb_o} !== 2'b10) begin
            errors++; $display("FAIL to_flag_set: timeout/stb=%b expected 10", {timeout_o, m_stb_o});
        end
        repeat (5) step();
        @(negedge wb_clk_i);
        checks++;
        if (timeout_o !== 1'b1) begin
            errors++; $display("FAIL to_flag_sticky: timeout_o=%b expected 1", timeout_o);
        end
        step();
        drive_idle();
        model_last = 1'b0;
`else
        // No timeout: the grant is held as long as the slave stays silent.
        ib_adr_i = 32'h0000_0800; ib_stb_i = 1'b1;
        step();
        repeat (20) step();
        @(negedge wb_clk_i);
        checks++;
        if ({m_stb_o, ib_ack_o, timeout_o} !== 3'b100) begin
            errors++; $display("FAIL noto_hold: stb/ib_ack/timeout=%b expected 100", {m_stb_o, ib_ack_o, timeout_o});
        end
        step();
        m_ack_i = 1'b1; m_dat_i = 32'h4242_4242;
        @(negedge wb_clk_i);
        checks++;
        if ({ib_ack_o, ib_dat_o} !== {1'b1, 32'h4242_4242}) begin
            errors++; $display("FAIL noto_ack: ack=%b data=%h expected 1 42424242", ib_ack_o, ib_dat_o);
        end
        step();
        drive_idle();
        model_last = 1'b0;
`endif
    endtask

    initial begin
        drive_idle();
        wb_rst_i = 1'b0;
        test_reset();
        test_conflict();
        test_ibus_read();
        test_alternate();
        test_reset_mid();
        test_abort();
        test_random_mix();
        test_timeout();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
